// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared writeback widths and arbiter state encoding (package rv_wb_pkg)
package rv_wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int STARVE_W   = 4;

  typedef enum logic {
    PRIO_MEM = 1'b0,
    PRIO_ALU = 1'b1
  } arb_state_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - requester, register-file write port and scoreboard lookup signals
interface regfile_wb_arbiter_if
  import rv_wb_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
);

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_a3;
  logic [DATA_W-1:0] rf_wd;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_rd;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic              rs1_busy;
  logic              rs2_busy;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output iss_valid, iss_rd, rs1, rs2,
    input  alu_ready, mem_ready, rf_we, rf_a3, rf_wd, rs1_busy, rs2_busy
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  iss_valid, iss_rd, rs1, rs2,
    output alu_ready, mem_ready, rf_we, rf_a3, rf_wd, rs1_busy, rs2_busy
  );

endinterface

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// rtl/regfile_wb_arbiter_wb_scoreboard.sv - pending-load mask with set/clear and two lookup ports
module wb_scoreboard
  import rv_wb_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_idx,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_idx,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              rs1_busy,
  output logic              rs2_busy
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0] mask;
  logic [NREG-1:0] mask_nxt;

  // Clear first, then set, so a same-cycle issue to the same register keeps it busy; x0 is never set.
  always_comb begin
    mask_nxt = mask;
    for (int i = 0; i < NREG; i++) begin
      if (clr_en && clr_idx == ADDR_W'(i)) mask_nxt[i] = 1'b0;
      if (set_en && set_idx == ADDR_W'(i) && i != 0) mask_nxt[i] = 1'b1;
    end
  end

  // Mask register.
  always_ff @(posedge CLK) begin
    if (RST) mask <= '0;
    else     mask <= mask_nxt;
  end

  assign rs1_busy = (rs1 != '0) && mask[rs1];
  assign rs2_busy = (rs2 != '0) && mask[rs2];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - MEM>ALU writeback arbiter with starvation guard; optional scoreboard via WB_SCOREBOARD_EN
module regfile_wb_arbiter
  import rv_wb_pkg::*;
#(
  parameter int DATA_W       = XLEN,
  parameter int ADDR_W       = REG_ADDR_W,
  parameter int STARVE_LIMIT = 4
) (
  input logic                 CLK,
  input logic                 RST,
  regfile_wb_arbiter_if.slave bus
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  arb_state_e          state;
  logic [STARVE_W-1:0] starve_cnt;
  logic [STARVE_W-1:0] starve_nxt;
  logic                grant_alu;
  logic                grant_mem;
  logic                grant_any;
  logic [ADDR_W-1:0]   win_rd;
  logic [DATA_W-1:0]   win_data;
  logic                rf_we_q;
  logic [ADDR_W-1:0]   rf_a3_q;
  logic [DATA_W-1:0]   rf_wd_q;

  // Grant: the state picks which requester wins a collision; a lone requester always wins.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (state == PRIO_ALU) begin
      grant_alu = bus.alu_valid;
      grant_mem = bus.mem_valid && !bus.alu_valid;
    end else begin
      grant_mem = bus.mem_valid;
      grant_alu = bus.alu_valid && !bus.mem_valid;
    end
  end

  // Winner mux and starvation counter next value (saturating, cleared by an ALU grant).
  always_comb begin
    grant_any  = grant_alu || grant_mem;
    win_rd     = grant_alu ? bus.alu_rd   : bus.mem_rd;
    win_data   = grant_alu ? bus.alu_data : bus.mem_data;
    starve_nxt = starve_cnt;
    if (grant_alu)
      starve_nxt = '0;
    else if (bus.alu_valid && starve_cnt != LIMIT)
      starve_nxt = starve_cnt + 1'b1;
  end

  // Arbiter FSM, counter and registered write port; x0 grants are consumed without writing.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= PRIO_MEM;
      starve_cnt <= '0;
      rf_we_q    <= 1'b0;
      rf_a3_q    <= '0;
      rf_wd_q    <= '0;
    end else begin
      starve_cnt <= starve_nxt;
      if (state == PRIO_MEM && starve_nxt == LIMIT)
        state <= PRIO_ALU;
      else
        state <= PRIO_MEM;
      rf_we_q <= grant_any && (win_rd != '0);
      if (grant_any && win_rd != '0) begin
        rf_a3_q <= win_rd;
        rf_wd_q <= win_data;
      end
    end
  end

  assign bus.alu_ready = grant_alu;
  assign bus.mem_ready = grant_mem;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_a3     = rf_a3_q;
  assign bus.rf_wd     = rf_wd_q;

`ifdef WB_SCOREBOARD_EN
  wb_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .CLK      (CLK),
    .RST      (RST),
    .set_en   (bus.iss_valid),
    .set_idx  (bus.iss_rd),
    .clr_en   (grant_mem),
    .clr_idx  (bus.mem_rd),
    .rs1      (bus.rs1),
    .rs2      (bus.rs2),
    .rs1_busy (bus.rs1_busy),
    .rs2_busy (bus.rs2_busy)
  );
`else
  logic unused_sb;
  assign unused_sb    = ^{bus.iss_valid, bus.iss_rd, bus.rs1, bus.rs2};
  assign bus.rs1_busy = 1'b0;
  assign bus.rs2_busy = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed and random bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  localparam int LIMIT = 4;
`ifdef WB_SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(
    .DATA_W       (32),
    .ADDR_W       (5),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    n_fail++;
    $error("FAIL timeout: test did not finish within the wait limit");
    $finish;
  end

  // Reference model: consecutive ALU-blocked cycles, expected write port, pending-load set.
  int          m_blocked;
  bit          exp_we;
  logic [4:0]  exp_a3;
  logic [31:0] exp_wd;
  bit          pend [32];

  task automatic model_reset();
    m_blocked = 0;
    exp_we    = 1'b0;
    exp_a3    = '0;
    exp_wd    = '0;
    for (int i = 0; i < 32; i++) pend[i] = 1'b0;
  endtask

  task automatic drive_idle();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0; bus.rs1 = '0; bus.rs2 = '0;
  endtask

  // One clock of stimulus; checks readies against the model, then the registered outputs.
  task automatic cycle(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                       input bit mv, input logic [4:0] mrd, input logic [31:0] md,
                       input bit iv, input logic [4:0] ird,
                       input logic [4:0] r1, input logic [4:0] r2,
                       output bit obs_ar, output bit obs_mr);
    bit ag;
    bit mg;
    @(negedge CLK);
    bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = ad;
    bus.mem_valid = mv; bus.mem_rd = mrd; bus.mem_data = md;
    bus.iss_valid = iv; bus.iss_rd = ird; bus.rs1 = r1; bus.rs2 = r2;
    ag = av && (!mv || m_blocked >= LIMIT);
    mg = mv && !ag;
    #1;
    obs_ar = bus.alu_ready;
    obs_mr = bus.mem_ready;
    check("alu_ready", bus.alu_ready, ag);
    check("mem_ready", bus.mem_ready, mg);
    if (ag) m_blocked = 0;
    else if (av && m_blocked < LIMIT) m_blocked++;
    if (ag && ard != 0) begin
      exp_we = 1'b1; exp_a3 = ard; exp_wd = ad;
    end else if (mg && mrd != 0) begin
      exp_we = 1'b1; exp_a3 = mrd; exp_wd = md;
    end else begin
      exp_we = 1'b0;
    end
    if (mg) pend[mrd] = 1'b0;
    if (iv && ird != 0) pend[ird] = 1'b1;
    @(posedge CLK);
    #1;
    check("rf_we", bus.rf_we, exp_we);
    check("rf_a3", bus.rf_a3, exp_a3);
    check("rf_wd", bus.rf_wd, exp_wd);
    check("rs1_busy", bus.rs1_busy, SB_EN && pend[r1]);
    check("rs2_busy", bus.rs2_busy, SB_EN && pend[r2]);
  endtask

  initial begin
    bit          oa, om;
    bit          a_pend, m_pend, iv;
    logic [4:0]  a_rd, m_rd, ird, r1, r2;
    logic [31:0] a_d, m_d;
    int          first_alu;
    bit          mem_after;

    drive_idle();
    model_reset();

    // Reset hold for two cycles.
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_rf_we", bus.rf_we, 1'b0);
    check("reset_rf_a3", bus.rf_a3, 5'd0);
    check("reset_rf_wd", bus.rf_wd, 32'd0);
    check("reset_rs1_busy", bus.rs1_busy, 1'b0);
    check("reset_rs2_busy", bus.rs2_busy, 1'b0);
    @(negedge CLK);
    RST = 1'b0;

    // Single ALU request.
    cycle(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, oa, om);
    check("t2_alu_ready", oa, 1'b1);
    check("t2_rf_we", bus.rf_we, 1'b1);
    check("t2_rf_a3", bus.rf_a3, 5'd5);
    check("t2_rf_wd", bus.rf_wd, 32'hDEADBEEF);

    // Collision: MEM first, ALU next cycle.
    cycle(1, 5'd4, 32'h44, 1, 5'd3, 32'h33, 0, 0, 0, 0, oa, om);
    check("t3_mem_first", om, 1'b1);
    check("t3_alu_blocked", oa, 1'b0);
    check("t3_rf_a3_first", bus.rf_a3, 5'd3);
    cycle(1, 5'd4, 32'h44, 0, 0, 0, 0, 0, 0, 0, oa, om);
    check("t3_alu_second", oa, 1'b1);
    check("t3_rf_a3_second", bus.rf_a3, 5'd4);

    // Starvation: MEM held 10 cycles with ALU also held.
    first_alu = 0;
    mem_after = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cycle(1, 5'd9, 32'h900 + i, 1, 5'(10 + i), 32'hA00 + i, 0, 0, 0, 0, oa, om);
      if (oa && first_alu == 0) first_alu = i;
      if (i == 6) mem_after = om;
    end
    check("t4_alu_grant_cycle", first_alu, 5);
    check("t4_mem_resumes", mem_after, 1'b1);

    // ALU write to x0 is consumed without writing.
    cycle(1, 5'd0, 32'h12345678, 0, 0, 0, 0, 0, 0, 0, oa, om);
    check("t5_alu_ready", oa, 1'b1);
    check("t5_rf_we", bus.rf_we, 1'b0);

    // Scoreboard set, clear, and same-cycle set-wins.
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd0, oa, om);
    check("t6_busy_after_issue", bus.rs1_busy, SB_EN);
    cycle(0, 0, 0, 1, 5'd7, 32'h77, 0, 0, 5'd7, 5'd7, oa, om);
    check("t6_clear_after_load", bus.rs1_busy, 1'b0);
    cycle(0, 0, 0, 1, 5'd7, 32'h78, 1, 5'd7, 5'd7, 5'd7, oa, om);
    check("t6_set_wins", bus.rs2_busy, SB_EN);
    cycle(0, 0, 0, 1, 5'd7, 32'h79, 0, 0, 5'd7, 5'd0, oa, om);

    // Randomized traffic; requesters hold requests until accepted.
    a_pend = 1'b0;
    m_pend = 1'b0;
    a_rd = '0; m_rd = '0; a_d = '0; m_d = '0;
    for (int i = 0; i < 300; i++) begin
      if (!a_pend && $urandom_range(0, 99) < 60) begin
        a_pend = 1'b1; a_rd = 5'($urandom); a_d = $urandom;
      end
      if (!m_pend && $urandom_range(0, 99) < 55) begin
        m_pend = 1'b1; m_rd = 5'($urandom); m_d = $urandom;
      end
      iv  = ($urandom_range(0, 3) == 0);
      ird = 5'($urandom);
      r1  = ($urandom_range(0, 1) == 0) ? ird : 5'($urandom);
      r2  = ($urandom_range(0, 1) == 0) ? m_rd : 5'($urandom);
      cycle(a_pend, a_rd, a_d, m_pend, m_rd, m_d, iv, ird, r1, r2, oa, om);
      if (oa) a_pend = 1'b0;
      if (om) m_pend = 1'b0;
    end

    // Reset in the middle of a grant drops it.
    cycle(1, 5'd17, 32'hCAFE0017, 0, 0, 0, 1, 5'd17, 5'd17, 0, oa, om);
    @(negedge CLK);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd12; bus.alu_data = 32'h0BADF00D;
    bus.iss_valid = 1'b0; bus.rs1 = 5'd17;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("midreset_rf_we", bus.rf_we, 1'b0);
    check("midreset_rf_a3", bus.rf_a3, 5'd0);
    check("midreset_rf_wd", bus.rf_wd, 32'd0);
    check("midreset_rs1_busy", bus.rs1_busy, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    drive_idle();
    model_reset();
    cycle(0, 0, 0, 1, 5'd21, 32'h2121, 0, 0, 0, 0, oa, om);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
